// File: rtl/regfile_pkg.sv
// Shared regfile definitions: width/constant macros (the defines.v set) and the FSM state type.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
`ifndef REGFILE_DEFINES_SV
`define REGFILE_DEFINES_SV
`define RADDR_WIDTH  5
`define RDATA_WIDTH  32
`define ZERO         32'h0000_0000
`define ZERO_REG     5'd0
`define REG_NUM      32
`define READ_ENABLE  1'b1
`define WRITE_ENABLE 1'b1
`endif

package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned AW = `RADDR_WIDTH;
  localparam int unsigned DW = `RDATA_WIDTH;

  // Clear walks entries 1..31; entry 0 is never stored.
  localparam logic [`RADDR_WIDTH-1:0] CLR_FIRST = `RADDR_WIDTH'(1);
  localparam logic [`RADDR_WIDTH-1:0] CLR_LAST  = `RADDR_WIDTH'(`REG_NUM - 1);

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: one write port, two read ports and the clear-done flag.
// Handshake: no valid/ready flow control; a write is taken on any rising clk edge with
// reg_we_i high while ready_o is high, and reads are purely combinational.
interface regfile_if;
  logic [`RADDR_WIDTH-1:0] reg_waddr_i;
  logic                    reg_we_i;
  logic [`RDATA_WIDTH-1:0] reg_wdata_i;
  logic                    reg1_re_i;
  logic [`RADDR_WIDTH-1:0] reg1_raddr_i;
  logic                    reg2_re_i;
  logic [`RADDR_WIDTH-1:0] reg2_raddr_i;
  logic [`RDATA_WIDTH-1:0] reg1_rdata_o;
  logic [`RDATA_WIDTH-1:0] reg2_rdata_o;
  logic                    ready_o;

  modport master (
    output reg_waddr_i, reg_we_i, reg_wdata_i,
    output reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
    input  reg1_rdata_o, reg2_rdata_o, ready_o
  );

  modport slave (
    input  reg_waddr_i, reg_we_i, reg_wdata_i,
    input  reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
    output reg1_rdata_o, reg2_rdata_o, ready_o
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: zero for x0, disabled reads and while clearing; otherwise the stored
// entry, or the in-flight write data when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
(
    input  logic                    run_i,
    input  logic                    re_i,
    input  logic [`RADDR_WIDTH-1:0] raddr_i,
    input  logic [`RDATA_WIDTH-1:0] stored_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                    we_i,
    input  logic [`RADDR_WIDTH-1:0] waddr_i,
    input  logic [`RDATA_WIDTH-1:0] wdata_i,
`endif
    output logic [`RDATA_WIDTH-1:0] rdata_o
);

    always_comb begin
        rdata_o = `ZERO;
        if (run_i && (re_i == `READ_ENABLE) && (raddr_i != `ZERO_REG)) begin
            rdata_o = stored_i;
`ifdef REGFILE_BYPASS_EN
            if ((we_i == `WRITE_ENABLE) && (waddr_i != `ZERO_REG) && (waddr_i == raddr_i)) begin
                rdata_o = wdata_i;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// 31-entry register file (x0 hard-wired to zero) with an unreset array that a CLEAR
// FSM zeroes after every reset. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile
  import regfile_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    regfile_if.slave  bus,
    output rf_state_e dbg_state_o
);

    rf_state_e               state_q, state_d;
    logic [`RADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                    ready_q;
    logic                    clr_active;

    // No reset on the array so it can map onto RAM; the FSM zeroes it instead.
    logic [`RDATA_WIDTH-1:0] mem [1:`REG_NUM-1];

    logic                    arr_we;
    logic [`RADDR_WIDTH-1:0] arr_addr;
    logic [`RDATA_WIDTH-1:0] arr_data;
    logic [`RDATA_WIDTH-1:0] stored1, stored2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= CLR_FIRST;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_active = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_active = 1'b1;
                clr_cnt_d  = clr_cnt_q + `RADDR_WIDTH'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // The clear owns the array's single write port; bus writes are dropped until RUN.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = clr_cnt_q;
        arr_data = `ZERO;
        if (clr_active) begin
            arr_we = 1'b1;
        end else if ((bus.reg_we_i == `WRITE_ENABLE) && (bus.reg_waddr_i != `ZERO_REG)) begin
            arr_we   = 1'b1;
            arr_addr = bus.reg_waddr_i;
            arr_data = bus.reg_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    always_comb begin
        stored1 = `ZERO;
        stored2 = `ZERO;
        if (bus.reg1_raddr_i != `ZERO_REG) stored1 = mem[bus.reg1_raddr_i];
        if (bus.reg2_raddr_i != `ZERO_REG) stored2 = mem[bus.reg2_raddr_i];
    end

    regfile_rd_port u_rd1 (
        .run_i    (state_q == ST_RUN),
        .re_i     (bus.reg1_re_i),
        .raddr_i  (bus.reg1_raddr_i),
        .stored_i (stored1),
`ifdef REGFILE_BYPASS_EN
        .we_i     (bus.reg_we_i),
        .waddr_i  (bus.reg_waddr_i),
        .wdata_i  (bus.reg_wdata_i),
`endif
        .rdata_o  (bus.reg1_rdata_o)
    );

    regfile_rd_port u_rd2 (
        .run_i    (state_q == ST_RUN),
        .re_i     (bus.reg2_re_i),
        .raddr_i  (bus.reg2_raddr_i),
        .stored_i (stored2),
`ifdef REGFILE_BYPASS_EN
        .we_i     (bus.reg_we_i),
        .waddr_i  (bus.reg_waddr_i),
        .wdata_i  (bus.reg_wdata_i),
`endif
        .rdata_o  (bus.reg2_rdata_o)
    );

    assign bus.ready_o = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile.sv
// Randomized and directed checks of regfile against an array model that counts
// clock edges since reset release to know when the clear is done.
module tb_regfile;
  import regfile_pkg::*;

  logic      clk_i;
  logic      rst_i;
  rf_state_e dbg_state;

  regfile_if bus ();

  regfile dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // reference model
  logic [31:0] model_mem [0:31];
  int          since_rel;
  int          n_cmp;
  int          n_bad;

  function automatic logic model_ready();
    return since_rel >= 31;
  endfunction

  function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (!model_ready() || !re || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return model_mem[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    since_rel = 0;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs at negedge, check reads before the edge, then update the model
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    @(negedge clk_i);
    bus.reg_we_i     = we;
    bus.reg_waddr_i  = wa;
    bus.reg_wdata_i  = wd;
    bus.reg1_re_i    = re1;
    bus.reg1_raddr_i = ra1;
    bus.reg2_re_i    = re2;
    bus.reg2_raddr_i = ra2;
    #1;
    check("ready", {31'b0, bus.ready_o}, {31'b0, model_ready()});
    check("rd1", bus.reg1_rdata_o, model_read(re1, ra1, we, wa, wd));
    check("rd2", bus.reg2_rdata_o, model_read(re2, ra2, we, wa, wd));
    @(posedge clk_i);
    if (model_ready() && we && wa != 5'd0) model_mem[wa] = wd;
    if (since_rel < 31) since_rel++;
  endtask

  task automatic idle_read(input logic [4:0] ra1, input logic [4:0] ra2);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, ra1, 1'b1, ra2);
  endtask

  // asynchronous reset pulse launched just after a rising edge
  task automatic pulse_reset(input int edges);
    @(posedge clk_i);
    #2;
    bus.reg1_re_i    = 1'b1;
    bus.reg1_raddr_i = 5'd1;
    rst_i = 1'b1;
    #1;
    check("rst_ready_async", {31'b0, bus.ready_o}, 32'h0);
    check("rst_rd1_zero", bus.reg1_rdata_o, 32'h0);
    model_reset();
    repeat (edges) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;
    n_cmp = 0;
    n_bad = 0;
    rst_i = 1'b1;
    bus.reg_we_i = 1'b0; bus.reg_waddr_i = 5'd0; bus.reg_wdata_i = 32'h0;
    bus.reg1_re_i = 1'b0; bus.reg1_raddr_i = 5'd0;
    bus.reg2_re_i = 1'b0; bus.reg2_raddr_i = 5'd0;
    model_reset();
    #1;
    check("reset_ready", {31'b0, bus.ready_o}, 32'h0);
    pulse_reset(2);

    // clear window: ready low for 31 edges, reads zero, write to x3 at cycle 5 dropped
    for (int c = 0; c < 31; c++) begin
      if (c == 5) cycle(1'b1, 5'd3, 32'hFF, 1'b1, 5'd3, 1'b1, 5'($urandom_range(0, 31)));
      else        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'($urandom_range(0, 31)), 1'b1, 5'd3);
    end
    idle_read(5'd3, 5'd3);

    // write then read on both ports, and disabled read
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(5'd5, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);

    // x0 protection
    cycle(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);
    idle_read(5'd0, 5'd0);
    idle_read(5'd0, 5'd5);

    // same-cycle read of the address being written
    cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 1'b1, 5'd7);
    idle_read(5'd7, 5'd7);

    // fill, read back, reset mid-operation, expect everything zero after the clear
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 1; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));
    pulse_reset(1);
    for (int c = 0; c < 31; c++) idle_read(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
    for (int i = 1; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));

    // randomized traffic, addresses biased toward a small window to provoke collisions
    for (int c = 0; c < 400; c++) begin
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      ra2 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      wd  = $urandom;
      cycle(1'($urandom_range(0, 1)), wa, wd, 1'($urandom_range(0, 3) != 0), ra1,
            1'($urandom_range(0, 3) != 0), ra2);
      if (c == 200) pulse_reset($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
